// File: rtl/cgra_kernel_dispatcher_pkg.sv
// Shared types and word layout for the CGRA kernel dispatcher.
// Grid geometry lives here so every stage agrees on the kmem word format.
package cgra_kernel_dispatcher_pkg;

    localparam int N_COL          = 4;
    localparam int KER_CONF_N_REG = 16;
    localparam int IMEM_N_LINES   = 128;
    localparam int RCS_NUM_CREG   = 32;

    localparam int KER_ID_W   = $clog2(KER_CONF_N_REG);
    localparam int IMEM_ADD_W = $clog2(IMEM_N_LINES);
    localparam int NINSTR_W   = $clog2(RCS_NUM_CREG);
    localparam int WORD_W     = N_COL + IMEM_ADD_W + NINSTR_W;

    localparam int NINSTR_LSB = 0;
    localparam int NINSTR_HSB = NINSTR_LSB + NINSTR_W - 1;
    localparam int IMEM_LSB   = NINSTR_HSB + 1;
    localparam int IMEM_HSB   = IMEM_LSB + IMEM_ADD_W - 1;
    localparam int MASK_LSB   = IMEM_HSB + 1;
    localparam int MASK_HSB   = MASK_LSB + N_COL - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ALLOC  = 2'd3
    } disp_state_e;

    typedef enum logic {
        ALLOC_FIXED = 1'b0,
        ALLOC_RELOC = 1'b1
    } alloc_mode_e;

    typedef struct packed {
        logic [N_COL-1:0]      col_mask;
        logic [IMEM_ADD_W-1:0] imem_add;
        logic [NINSTR_W-1:0]   n_instr;
    } kmem_word_t;

    function automatic int popcount(input logic [N_COL-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < N_COL; i++) begin
            c = c + int'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/cgra_kernel_dispatcher_col.sv
// Column allocator: picks the target column set for a kernel mask.
// Fixed mode uses the mask as-is; relocatable mode finds the lowest free run.
module cgra_col_allocator
    import cgra_kernel_dispatcher_pkg::*;
(
    input  logic [N_COL-1:0] free_i,
    input  logic [N_COL-1:0] req_i,
    input  alloc_mode_e      mode_i,
    output logic [N_COL-1:0] target_o,
    output logic             found_o
);

    logic [N_COL-1:0] win;
    int               cnt;

    always_comb begin
        cnt      = popcount(req_i);
        win      = '0;
        target_o = '0;
        found_o  = 1'b0;
        for (int j = 0; j < N_COL; j++) begin
            win[j] = (j < cnt);
        end
        if (mode_i == ALLOC_FIXED) begin
            target_o = req_i;
            found_o  = (|req_i) && ((req_i & ~free_i) == '0);
        end else if (cnt != 0) begin
            // Scan downwards so the lowest fitting position wins.
            for (int i = N_COL - 1; i >= 0; i--) begin
                if ((i + cnt <= N_COL) && (((win << i) & ~free_i) == '0)) begin
                    target_o = win << i;
                    found_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cgra_kernel_dispatcher.sv
// Multi-slot kernel launch engine for the CGRA columns.
// Optional CGRA_DISPATCH_PERF_CNT_EN adds per-slot ALLOC stall counters.
module cgra_kernel_dispatcher
    import cgra_kernel_dispatcher_pkg::*;
#(
    parameter int N_SLOTS    = 2,
    parameter int ALLOC_MODE = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_SLOTS-1:0]           slot_req_i,
    input  logic [N_SLOTS*KER_ID_W-1:0]  slot_ker_id_i,
    output logic [N_SLOTS-1:0]           slot_ack_o,
    output logic [N_SLOTS-1:0]           slot_err_o,
    output logic [N_SLOTS-1:0]           slot_done_o,
    output logic [N_SLOTS-1:0]           slot_busy_o,
    output logic                         kmem_req_o,
    output logic [KER_ID_W-1:0]          kmem_addr_o,
    input  logic [WORD_W-1:0]            kmem_rdata_i,
    output logic [N_COL-1:0]             col_start_o,
    output logic [IMEM_ADD_W-1:0]        col_imem_add_o,
    output logic [NINSTR_W-1:0]          col_n_instr_o,
    input  logic [N_COL-1:0]             col_done_i,
    output logic [N_COL-1:0]             cols_busy_o
`ifdef CGRA_DISPATCH_PERF_CNT_EN
    ,
    output logic [N_SLOTS*32-1:0]        stall_cnt_o
`endif
);

    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam alloc_mode_e MODE = (ALLOC_MODE != 0) ? ALLOC_RELOC : ALLOC_FIXED;

    disp_state_e                     state_q, state_d;
    logic [SLOT_W-1:0]               ptr_q, ptr_d;
    logic [SLOT_W-1:0]               sel_q, sel_d;
    kmem_word_t                      word_q, word_d;
    logic [N_COL-1:0]                busy_q, busy_d;
    logic [N_SLOTS-1:0][N_COL-1:0]   owner_q, owner_d;
    logic [N_SLOTS-1:0]              done_q, done_d;

    logic [N_SLOTS-1:0][KER_ID_W-1:0] ids;
    logic [N_SLOTS-1:0]              owned;
    logic [N_SLOTS-1:0]              elig;
    logic [N_SLOTS-1:0]              sel_oh;
    logic [SLOT_W-1:0]               cand;
    logic [SLOT_W-1:0]               pick;
    logic                            pick_vld;
    logic [N_COL-1:0]                free;
    logic [N_COL-1:0]                target;
    logic                            found;
    logic                            grant;
    logic                            reject;
    logic                            run;

    assign ids  = slot_ker_id_i;
    assign run  = !rst_i;
    assign elig = slot_req_i & ~owned;
    // A column finishing this cycle is already free for a new start.
    assign free = ~(busy_q & ~col_done_i);

    always_comb begin
        owned  = '0;
        sel_oh = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            owned[s] = |owner_q[s];
        end
        sel_oh[sel_q] = 1'b1;
    end

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            cand = SLOT_W'((int'(ptr_q) + k) % N_SLOTS);
            if (!pick_vld && elig[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    cgra_col_allocator u_alloc (
        .free_i   (free),
        .req_i    (word_q.col_mask),
        .mode_i   (MODE),
        .target_o (target),
        .found_o  (found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        word_d  = word_q;
        busy_d  = busy_q & ~col_done_i;
        grant   = 1'b0;
        reject  = 1'b0;
        for (int s = 0; s < N_SLOTS; s++) begin
            owner_d[s] = owner_q[s] & ~col_done_i;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                word_d  = kmem_word_t'(kmem_rdata_i);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if ((word_q.col_mask == '0) ||
                    ((MODE == ALLOC_RELOC) &&
                     (popcount(word_q.col_mask) > N_COL))) begin
                    reject  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (found) begin
                    grant          = 1'b1;
                    busy_d         = busy_d | target;
                    owner_d[sel_q] = owner_d[sel_q] | target;
                    ptr_d          = (int'(sel_q) == N_SLOTS - 1) ? '0 : sel_q + 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        for (int s = 0; s < N_SLOTS; s++) begin
            done_d[s] = (|owner_q[s]) && !(|owner_d[s]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            busy_q  <= '0;
            owner_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            done_q  <= done_d;
        end
    end

    assign kmem_req_o     = run && (state_q == ST_IDLE) && pick_vld;
    assign kmem_addr_o    = kmem_req_o ? ids[pick] : '0;
    assign col_start_o    = (run && grant) ? target : '0;
    assign col_imem_add_o = (run && grant) ? word_q.imem_add : '0;
    assign col_n_instr_o  = (run && grant) ? word_q.n_instr : '0;
    assign slot_ack_o     = (run && (grant || reject)) ? sel_oh : '0;
    assign slot_err_o     = (run && reject) ? sel_oh : '0;
    assign slot_done_o    = run ? done_q : '0;
    assign slot_busy_o    = run ? owned : '0;
    assign cols_busy_o    = run ? busy_q : '0;

`ifdef CGRA_DISPATCH_PERF_CNT_EN
    logic [N_SLOTS-1:0][31:0] stall_q;

    // Counts cycles a slot waits in ALLOC for its columns to free up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((state_q == ST_ALLOC) && !found &&
                     (stall_q[sel_q] != 32'hFFFF_FFFF)) begin
            stall_q[sel_q] <= stall_q[sel_q] + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_cgra_kernel_dispatcher.sv
// Testbench for cgra_kernel_dispatcher: fixed-mode cycle table
// plus a relocatable-mode sequence on a second instance.
module tb_cgra_kernel_dispatcher;

    logic clk;
    logic rst;

    logic [1:0]  req0, ack0, err0, sdone0, sbusy0;
    logic [7:0]  ids0;
    logic        kreq0;
    logic [3:0]  kaddr0, start0, done0, cbusy0;
    logic [15:0] rd0;
    logic [6:0]  add0;
    logic [4:0]  n0;

    logic [1:0]  req1, ack1, err1, sdone1, sbusy1;
    logic [7:0]  ids1;
    logic        kreq1;
    logic [3:0]  kaddr1, start1, done1, cbusy1;
    logic [15:0] rd1;
    logic [6:0]  add1;
    logic [4:0]  n1;

    logic [15:0] mem [16];
    logic [32:0] got0, got1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       nm;
        logic        r;
        logic [1:0]  rq;
        logic [7:0]  id;
        logic [3:0]  dn;
        logic [32:0] ex;
    } vec_t;

    vec_t vq[$];

    cgra_kernel_dispatcher #(.N_SLOTS(2), .ALLOC_MODE(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .slot_req_i(req0), .slot_ker_id_i(ids0),
        .slot_ack_o(ack0), .slot_err_o(err0),
        .slot_done_o(sdone0), .slot_busy_o(sbusy0),
        .kmem_req_o(kreq0), .kmem_addr_o(kaddr0), .kmem_rdata_i(rd0),
        .col_start_o(start0), .col_imem_add_o(add0), .col_n_instr_o(n0),
        .col_done_i(done0), .cols_busy_o(cbusy0)
    );

    cgra_kernel_dispatcher #(.N_SLOTS(2), .ALLOC_MODE(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .slot_req_i(req1), .slot_ker_id_i(ids1),
        .slot_ack_o(ack1), .slot_err_o(err1),
        .slot_done_o(sdone1), .slot_busy_o(sbusy1),
        .kmem_req_o(kreq1), .kmem_addr_o(kaddr1), .kmem_rdata_i(rd1),
        .col_start_o(start1), .col_imem_add_o(add1), .col_n_instr_o(n1),
        .col_done_i(done1), .cols_busy_o(cbusy1)
    );

    assign got0 = {ack0, err0, sdone0, sbusy0, kreq0, kaddr0, start0, add0, n0, cbusy0};
    assign got1 = {ack1, err1, sdone1, sbusy1, kreq1, kaddr1, start1, add1, n1, cbusy1};

    always #5 clk = ~clk;

    // Kernel memory: one-cycle read latency.
    always @(posedge clk) begin
        if (kreq0) rd0 <= mem[kaddr0];
        if (kreq1) rd1 <= mem[kaddr1];
    end

    function automatic logic [15:0] w(input logic [3:0] m, input logic [6:0] a,
                                      input logic [4:0] n);
        return {m, a, n};
    endfunction

    function automatic logic [32:0] pk(input logic [1:0] a, input logic [1:0] e,
                                       input logic [1:0] d, input logic [1:0] b,
                                       input logic k, input logic [3:0] ka,
                                       input logic [3:0] st, input logic [6:0] ad,
                                       input logic [4:0] n, input logic [3:0] cb);
        return {a, e, d, b, k, ka, st, ad, n, cb};
    endfunction

    function automatic logic [32:0] bz(input logic [1:0] b, input logic [3:0] cb);
        return pk(2'b00, 2'b00, 2'b00, b, 1'b0, 4'h0, 4'h0, 7'd0, 5'd0, cb);
    endfunction

    function automatic logic [32:0] fr(input logic [3:0] ka, input logic [1:0] b,
                                       input logic [3:0] cb);
        return pk(2'b00, 2'b00, 2'b00, b, 1'b1, ka, 4'h0, 7'd0, 5'd0, cb);
    endfunction

    function automatic logic [32:0] st(input logic [1:0] a, input logic [3:0] s,
                                       input logic [6:0] ad, input logic [4:0] n,
                                       input logic [1:0] b, input logic [3:0] cb);
        return pk(a, 2'b00, 2'b00, b, 1'b0, 4'h0, s, ad, n, cb);
    endfunction

    function automatic logic [32:0] dn(input logic [1:0] d, input logic [1:0] b,
                                       input logic [3:0] cb);
        return pk(2'b00, 2'b00, d, b, 1'b0, 4'h0, 4'h0, 7'd0, 5'd0, cb);
    endfunction

    function automatic void add_v(input string nm, input logic r, input logic [1:0] rq,
                                  input logic [7:0] id, input logic [3:0] d,
                                  input logic [32:0] ex);
        vec_t v;
        v.nm = nm; v.r = r; v.rq = rq; v.id = id; v.dn = d; v.ex = ex;
        vq.push_back(v);
    endfunction

    task automatic step1(input string nm, input logic [1:0] rq, input logic [7:0] id,
                         input logic [3:0] d, input logic [32:0] ex);
        @(negedge clk);
        req1 = rq; ids1 = id; done1 = d;
        #1;
        checks++;
        if (got1 !== ex) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got1, ex);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3] = w(4'b0011, 7'd10, 5'd5);
        mem[4] = w(4'b0001, 7'd20, 5'd2);
        mem[5] = w(4'b0100, 7'd30, 5'd3);
        mem[6] = w(4'b0000, 7'd99, 5'd9);
        mem[7] = w(4'b0011, 7'd40, 5'd7);
        mem[9] = w(4'b0111, 7'd50, 5'd9);

        // Two slots, disjoint masks, pointer starts at 0.
        add_v("rst",     1, 2'b00, 8'h54, 4'h0, bz(2'b00, 4'h0));
        add_v("b_req",   0, 2'b11, 8'h54, 4'h0, fr(4'h4, 2'b00, 4'h0));
        add_v("b_fetch", 0, 2'b11, 8'h54, 4'h0, bz(2'b00, 4'h0));
        add_v("b_dec",   0, 2'b11, 8'h54, 4'h0, bz(2'b00, 4'h0));
        add_v("b_st0",   0, 2'b11, 8'h54, 4'h0, st(2'b01, 4'b0001, 7'd20, 5'd2, 2'b00, 4'h0));
        add_v("b_req1",  0, 2'b10, 8'h54, 4'h0, fr(4'h5, 2'b01, 4'b0001));
        add_v("b_f1",    0, 2'b10, 8'h54, 4'h0, bz(2'b01, 4'b0001));
        add_v("b_d1",    0, 2'b10, 8'h54, 4'h0, bz(2'b01, 4'b0001));
        add_v("b_st1",   0, 2'b10, 8'h54, 4'h0, st(2'b10, 4'b0100, 7'd30, 5'd3, 2'b01, 4'b0001));
        add_v("b_done",  0, 2'b00, 8'h54, 4'b0101, bz(2'b11, 4'b0101));
        add_v("b_sdone", 0, 2'b00, 8'h54, 4'h0, dn(2'b11, 2'b00, 4'h0));
        // Single kernel, two columns finishing on different cycles.
        add_v("a_req",   0, 2'b01, 8'h53, 4'h0, fr(4'h3, 2'b00, 4'h0));
        add_v("a_fetch", 0, 2'b01, 8'h53, 4'h0, bz(2'b00, 4'h0));
        add_v("a_dec",   0, 2'b01, 8'h53, 4'h0, bz(2'b00, 4'h0));
        add_v("a_st",    0, 2'b01, 8'h53, 4'h0, st(2'b01, 4'b0011, 7'd10, 5'd5, 2'b00, 4'h0));
        add_v("a_run",   0, 2'b00, 8'h53, 4'h0, bz(2'b01, 4'b0011));
        add_v("a_dn0",   0, 2'b00, 8'h53, 4'b0001, bz(2'b01, 4'b0011));
        add_v("a_half",  0, 2'b00, 8'h53, 4'h0, bz(2'b01, 4'b0010));
        add_v("a_dn1",   0, 2'b00, 8'h53, 4'b0010, bz(2'b01, 4'b0010));
        add_v("a_sdone", 0, 2'b00, 8'h53, 4'h0, dn(2'b01, 2'b00, 4'h0));
        add_v("a_once",  0, 2'b00, 8'h53, 4'h0, bz(2'b00, 4'h0));
        // Pointer now 1: slot 1 wins the tie.
        add_v("c_req",   0, 2'b11, 8'h54, 4'h0, fr(4'h5, 2'b00, 4'h0));
        add_v("c_fetch", 0, 2'b11, 8'h54, 4'h0, bz(2'b00, 4'h0));
        add_v("c_dec",   0, 2'b11, 8'h54, 4'h0, bz(2'b00, 4'h0));
        add_v("c_st1",   0, 2'b11, 8'h54, 4'h0, st(2'b10, 4'b0100, 7'd30, 5'd3, 2'b00, 4'h0));
        add_v("c_req0",  0, 2'b01, 8'h54, 4'h0, fr(4'h4, 2'b10, 4'b0100));
        add_v("c_f0",    0, 2'b01, 8'h54, 4'h0, bz(2'b10, 4'b0100));
        add_v("c_d0",    0, 2'b01, 8'h54, 4'h0, bz(2'b10, 4'b0100));
        add_v("c_st0",   0, 2'b01, 8'h54, 4'h0, st(2'b01, 4'b0001, 7'd20, 5'd2, 2'b10, 4'b0100));
        add_v("c_dn1",   0, 2'b00, 8'h54, 4'b0100, bz(2'b11, 4'b0101));
        add_v("c_sdone", 0, 2'b00, 8'h54, 4'h0, dn(2'b10, 2'b01, 4'b0001));
        // Slot 1 wants column 0 while slot 0 still holds it.
        add_v("d_req",   0, 2'b10, 8'h44, 4'h0, fr(4'h4, 2'b01, 4'b0001));
        add_v("d_fetch", 0, 2'b10, 8'h44, 4'h0, bz(2'b01, 4'b0001));
        add_v("d_dec",   0, 2'b10, 8'h44, 4'h0, bz(2'b01, 4'b0001));
        add_v("d_hold0", 0, 2'b10, 8'h44, 4'h0, bz(2'b01, 4'b0001));
        add_v("d_hold1", 0, 2'b10, 8'h44, 4'h0, bz(2'b01, 4'b0001));
        add_v("d_same",  0, 2'b10, 8'h44, 4'b0001, st(2'b10, 4'b0001, 7'd20, 5'd2, 2'b01, 4'b0001));
        add_v("d_after", 0, 2'b00, 8'h44, 4'h0, dn(2'b01, 2'b10, 4'b0001));
        // Empty mask is rejected.
        add_v("e_req",   0, 2'b01, 8'h46, 4'h0, fr(4'h6, 2'b10, 4'b0001));
        add_v("e_fetch", 0, 2'b01, 8'h46, 4'h0, bz(2'b10, 4'b0001));
        add_v("e_err",   0, 2'b01, 8'h46, 4'h0,
              pk(2'b01, 2'b01, 2'b00, 2'b10, 1'b0, 4'h0, 4'h0, 7'd0, 5'd0, 4'b0001));
        add_v("e_after", 0, 2'b00, 8'h46, 4'h0, bz(2'b10, 4'b0001));
        // Two kernels live, then reset.
        add_v("f_req",   0, 2'b01, 8'h45, 4'h0, fr(4'h5, 2'b10, 4'b0001));
        add_v("f_fetch", 0, 2'b01, 8'h45, 4'h0, bz(2'b10, 4'b0001));
        add_v("f_dec",   0, 2'b01, 8'h45, 4'h0, bz(2'b10, 4'b0001));
        add_v("f_st",    0, 2'b01, 8'h45, 4'h0, st(2'b01, 4'b0100, 7'd30, 5'd3, 2'b10, 4'b0001));
        add_v("f_both",  0, 2'b00, 8'h45, 4'h0, bz(2'b11, 4'b0101));
        add_v("f_rst",   1, 2'b00, 8'h45, 4'h0, bz(2'b00, 4'h0));
        add_v("f_ldone", 0, 2'b00, 8'h45, 4'b0101, bz(2'b00, 4'h0));
        add_v("f_quiet", 0, 2'b00, 8'h45, 4'h0, bz(2'b00, 4'h0));

        clk = 0; rst = 1;
        req0 = '0; ids0 = '0; done0 = '0; rd0 = '0;
        req1 = '0; ids1 = '0; done1 = '0; rd1 = '0;
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].r; req0 = vq[i].rq; ids0 = vq[i].id; done0 = vq[i].dn;
            #1;
            checks++;
            if (got0 !== vq[i].ex) begin
                errors++;
                $display("FAIL %s: got %h want %h", vq[i].nm, got0, vq[i].ex);
            end
        end

        // Relocatable mode: 3-col kernel, then a 2-col kernel waits for a run.
        step1("m_req",   2'b11, 8'h79, 4'h0, fr(4'h9, 2'b00, 4'h0));
        step1("m_fetch", 2'b11, 8'h79, 4'h0, bz(2'b00, 4'h0));
        step1("m_dec",   2'b11, 8'h79, 4'h0, bz(2'b00, 4'h0));
        step1("m_st0",   2'b11, 8'h79, 4'h0, st(2'b01, 4'b0111, 7'd50, 5'd9, 2'b00, 4'h0));
        step1("m_req1",  2'b10, 8'h79, 4'h0, fr(4'h7, 2'b01, 4'b0111));
        step1("m_f1",    2'b10, 8'h79, 4'h0, bz(2'b01, 4'b0111));
        step1("m_d1",    2'b10, 8'h79, 4'h0, bz(2'b01, 4'b0111));
        step1("m_blk",   2'b10, 8'h79, 4'h0, bz(2'b01, 4'b0111));
        step1("m_gap",   2'b10, 8'h79, 4'b0010, bz(2'b01, 4'b0111));
        step1("m_frag",  2'b10, 8'h79, 4'h0, bz(2'b01, 4'b0101));
        step1("m_reloc", 2'b10, 8'h79, 4'b0100,
              st(2'b10, 4'b0110, 7'd40, 5'd7, 2'b01, 4'b0101));
        step1("m_both",  2'b00, 8'h79, 4'h0, bz(2'b11, 4'b0111));
        step1("m_dn0",   2'b00, 8'h79, 4'b0001, bz(2'b11, 4'b0111));
        step1("m_sdone", 2'b00, 8'h79, 4'h0, dn(2'b01, 2'b10, 4'b0110));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
